key_event_detect: RTL
=====================

// Module: key_event_detect
// PURPOSE
//  - Downstream of key debounce; upstream of beep/LED consumers. Classifies a debounced,
//    active-low key level into one-cycle event pulses: short press, double press, long press.
//  - Replaces raw-level use of the debounced key so that each consumer gets discrete events.
// PARAMETERS
//  - LONG_CNT    32'd50_000_000  hold time (cycles) qualifying a long press (1 s @ 50 MHz)
//  - DBL_CNT     32'd15_000_000  max release gap (cycles) allowing a second press (300 ms)
//  - REPEAT_CNT  32'd10_000_000  repeat interval while held after long press (KEY_REPEAT_EN only)
//  - CNT_W       derived: $clog2 of max(LONG_CNT, DBL_CNT, REPEAT_CNT)+1; localparam, not overridable
// PORTS
//  - sys_clk       in   1  system clock, 50 MHz
//  - sys_rst_n     in   1  asynchronous reset, active-low
//  - key_level     in   1  debounced key level; 0 = pressed, 1 = released
//  - short_press   out  1  one-cycle pulse: single press+release, no second press within DBL_CNT
//  - double_press  out  1  one-cycle pulse: second press released within the double window
//  - long_press    out  1  one-cycle pulse: key held LONG_CNT cycles
//  - key_repeat    out  1  one-cycle pulse every REPEAT_CNT cycles of hold after long_press
//  - key_busy      out  1  high whenever FSM is not IDLE
// BEHAVIOUR
//  - Reset: state=IDLE, cnt=0, key_d1=1, all outputs 0. Async assert; sync release.
//  - key_d1 registers key_level; fall = key_d1 & ~key_level; rise = ~key_d1 & key_level.
//  - cnt clears on every state change; increments otherwise; saturates at its terminal value.
//  - IDLE:   fall -> PRESS1. A key held low out of reset produces no event (no fall seen).
//  - PRESS1: rise before cnt==LONG_CNT-1 -> WAIT2; cnt==LONG_CNT-1 with key low -> LONG and
//            long_press=1 next cycle. Rise on the terminal cycle itself: rise wins (-> WAIT2).
//  - WAIT2:  fall before cnt==DBL_CNT-1 -> PRESS2; cnt==DBL_CNT-1 -> IDLE, short_press=1 next cycle.
//            Fall on the terminal cycle: fall wins (-> PRESS2).
//  - PRESS2: rise -> IDLE, double_press=1 next cycle. No long detection in PRESS2.
//  - LONG:   rise -> IDLE, no further event.
//  - Latency: every pulse is registered, exactly 1 cycle, high on the cycle after the deciding edge.
//  - At most one of short/double/long/repeat is high in any cycle.
//  - key_busy = (state != IDLE), registered alongside the state.
//  - Reset mid-operation: immediate return to IDLE, pending event discarded, no pulse.
// CONFIGURATION
//  - KEY_REPEAT_EN defined: in LONG, cnt counts to REPEAT_CNT-1, key_repeat pulses, cnt clears,
//    repeat continues until rise. First repeat comes REPEAT_CNT cycles after the long_press cycle.
//  - KEY_REPEAT_EN undefined: key_repeat tied 0; LONG only waits for rise; REPEAT_CNT unused.
// STRUCTURE
//  - Shared include key_defs.vh: state encodings (IDLE=0, PRESS1=1, WAIT2=2, PRESS2=3, LONG=4,
//    3-bit), default timing constants at 50 MHz (shared with key_debounce CNT_MAX).
//  - One sub-module: key_edge_det (key_d1 register, fall/rise outputs), reusable for other keys.
//  - FSM, counter, and output registers stay in key_event_detect.
// TESTING  (bench parameters: LONG_CNT=100, DBL_CNT=30, REPEAT_CNT=20)
//  - Press 10 cycles, release, idle 40 cycles -> one short_press 30 cycles after release; no other pulse.
//  - Press 10, release 10, press 10, release -> one double_press the cycle after second rise; no short.
//  - Hold 150 cycles -> long_press once, 100 cycles after the fall; release -> no extra event.
//  - KEY_REPEAT_EN, hold 165 cycles -> long_press at +100, key_repeat at +120, +140, +160; none after release.
//  - Key held low from reset release for 200 cycles -> no pulses; key_busy stays 0.
//  - Reset asserted at PRESS1 cycle 50, released, key released -> all outputs 0, state IDLE, no pulse.

Source files
------------

// File: rtl/key_event_detect_pkg.sv
// Shared state encoding, default 50 MHz timing constants and sizing helper for the key event classifier.
package key_event_detect_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRESS1 = 3'd1,
        WAIT2  = 3'd2,
        PRESS2 = 3'd3,
        LONG   = 3'd4
    } key_state_t;

    localparam int unsigned LONG_CNT_DEF   = 32'd50_000_000;
    localparam int unsigned DBL_CNT_DEF    = 32'd15_000_000;
    localparam int unsigned REPEAT_CNT_DEF = 32'd10_000_000;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/key_event_detect_edge_det.sv
// Registers a debounced key level and flags its falling and rising edges; reusable per key.
module key_event_detect_edge_det (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key_level,
    output logic fall,
    output logic rise
);

    logic key_d1;
    logic armed;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            key_d1 <= 1'b1;
            armed  <= 1'b0;
        end else begin
            key_d1 <= key_level;
            armed  <= 1'b1;
        end
    end

    // Edges are masked until key_d1 holds a real sample, so a key held low through reset is not a press.
    assign fall = armed &  key_d1 & ~key_level;
    assign rise = armed & ~key_d1 &  key_level;

endmodule

// File: rtl/key_event_detect.sv
// Classifies a debounced active-low key into short/double/long (and optional repeat) pulses.
// Optional auto-repeat while held after a long press: define KEY_REPEAT_EN.
module key_event_detect
    import key_event_detect_pkg::*;
#(
    parameter int unsigned LONG_CNT   = LONG_CNT_DEF,
    parameter int unsigned DBL_CNT    = DBL_CNT_DEF,
    parameter int unsigned REPEAT_CNT = REPEAT_CNT_DEF
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key_level,
    output logic short_press,
    output logic double_press,
    output logic long_press,
    output logic key_repeat,
    output logic key_busy
);

    localparam int unsigned      CNT_MAXV  = max3(LONG_CNT, DBL_CNT, REPEAT_CNT);
    localparam int unsigned      CNT_W     = $clog2(CNT_MAXV + 1);
    localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(CNT_MAXV);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);
    localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DBL_CNT - 1);
`ifdef KEY_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CNT - 1);
`endif

    key_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             fall;
    logic             rise;

    key_event_detect_edge_det u_edge (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .key_level (key_level),
        .fall      (fall),
        .rise      (rise)
    );

`ifdef KEY_REPEAT_EN
    logic repeat_q;
    assign key_repeat = repeat_q;
`else
    assign key_repeat = 1'b0;
`endif

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            short_press  <= 1'b0;
            double_press <= 1'b0;
            long_press   <= 1'b0;
            key_busy     <= 1'b0;
`ifdef KEY_REPEAT_EN
            repeat_q     <= 1'b0;
`endif
        end else begin
            short_press  <= 1'b0;
            double_press <= 1'b0;
            long_press   <= 1'b0;
`ifdef KEY_REPEAT_EN
            repeat_q     <= 1'b0;
`endif
            cnt <= (cnt == CNT_SAT) ? cnt : cnt + 1'b1;
            case (state)
                IDLE: begin
                    if (fall) begin
                        state    <= PRESS1;
                        cnt      <= '0;
                        key_busy <= 1'b1;
                    end
                end
                // Edge tests precede the terminal-count tests so an edge on the terminal cycle wins.
                PRESS1: begin
                    if (rise) begin
                        state <= WAIT2;
                        cnt   <= '0;
                    end else if (cnt == LONG_LAST) begin
                        state      <= LONG;
                        cnt        <= '0;
                        long_press <= 1'b1;
                    end
                end
                WAIT2: begin
                    if (fall) begin
                        state <= PRESS2;
                        cnt   <= '0;
                    end else if (cnt == DBL_LAST) begin
                        state       <= IDLE;
                        cnt         <= '0;
                        key_busy    <= 1'b0;
                        short_press <= 1'b1;
                    end
                end
                PRESS2: begin
                    if (rise) begin
                        state        <= IDLE;
                        cnt          <= '0;
                        key_busy     <= 1'b0;
                        double_press <= 1'b1;
                    end
                end
                LONG: begin
                    if (rise) begin
                        state    <= IDLE;
                        cnt      <= '0;
                        key_busy <= 1'b0;
`ifdef KEY_REPEAT_EN
                    end else if (cnt == REP_LAST) begin
                        cnt      <= '0;
                        repeat_q <= 1'b1;
`endif
                    end
                end
                default: begin
                    state    <= IDLE;
                    cnt      <= '0;
                    key_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
